// File: rtl/vector_strided_lsu.sv
// rtl/vector_strided_lsu.sv - strided, masked vector load/store engine issuing LANES elements per memory beat
// Moves one vector register between the VRF and a LANES-wide valid/ready data-memory port.
module vector_strided_lsu #(
  parameter int VLEN       = 128,
  parameter int ELEN       = 32,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int NELEM      = VLEN / ELEN,
  parameter int VLW        = $clog2(NELEM) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        is_store_i,
  input  logic [ADDR_WIDTH-1:0]       base_i,
  input  logic [ADDR_WIDTH-1:0]       stride_i,
  input  logic [VLW-1:0]              vl_i,
  input  logic [NELEM-1:0]            mask_i,
  input  logic [VLEN-1:0]             vs3_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [VLEN-1:0]             vd_data_o,
  output logic [NELEM-1:0]            vd_we_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [LANES-1:0]            mem_lane_en_o,
  output logic [LANES*ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LANES*ELEN-1:0]       mem_wdata_o,
  input  logic                        mem_ready_i,
  input  logic                        mem_rvalid_i,
  input  logic [LANES*ELEN-1:0]       mem_rdata_i
);
  localparam int EW = VLW + 1;

  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_e;

  state_e                      state_q, state_d;
  logic                        setup_q, setup_d;
  logic                        is_store_q, is_store_d;
  logic [VLW-1:0]              vl_q, vl_d;
  logic [NELEM-1:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]       stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]       bb_q, bb_d;
  logic [EW-1:0]               e0_q, e0_d;
  logic [ELEN-1:0]             buf_q [NELEM];
  logic [ELEN-1:0]             buf_d [NELEM];
  logic                        mem_req_q, mem_req_d;
  logic                        mem_we_q, mem_we_d;
  logic [LANES-1:0]            en_q, en_d;
  logic [LANES*ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LANES*ELEN-1:0]       wdata_q, wdata_d;

  logic [EW-1:0]               adv_e0, beat_e0;
  logic [ADDR_WIDTH-1:0]       adv_bb, beat_bb;
  logic [LANES-1:0]            beat_en;
  logic [LANES*ADDR_WIDTH-1:0] beat_addr;
  logic [LANES*ELEN-1:0]       beat_wdata;
  logic                        advance, load_beat;

  // The setup cycle after start loads beat 0; every later load is the beat after the current one.
  assign adv_e0  = e0_q + EW'(LANES);
  assign adv_bb  = bb_q + ADDR_WIDTH'(LANES) * stride_q;
  assign beat_e0 = setup_q ? e0_q : adv_e0;
  assign beat_bb = setup_q ? bb_q : adv_bb;

  always_comb begin
    beat_en    = '0;
    beat_addr  = '0;
    beat_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = beat_bb + ADDR_WIDTH'(i) * stride_q;
      if (int'(beat_e0) + i < NELEM) begin
        beat_wdata[i*ELEN +: ELEN] = buf_q[int'(beat_e0) + i];
        beat_en[i] = mask_q[int'(beat_e0) + i] && (int'(beat_e0) + i < int'(vl_q));
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    setup_d    = setup_q;
    is_store_d = is_store_q;
    vl_d       = vl_q;
    mask_d     = mask_q;
    stride_d   = stride_q;
    bb_d       = bb_q;
    e0_d       = e0_q;
    buf_d      = buf_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    en_d       = en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    advance    = 1'b0;
    load_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = REQ;
          setup_d    = 1'b1;
          is_store_d = is_store_i;
          vl_d       = vl_i;
          mask_d     = mask_i;
          stride_d   = stride_i;
          bb_d       = base_i;
          e0_d       = '0;
          for (int j = 0; j < NELEM; j++) buf_d[j] = vs3_i[j*ELEN +: ELEN];
        end
      end
      REQ: begin
        if (setup_q) begin
          setup_d = 1'b0;
          if (vl_q == '0) state_d = DONE;
          else            load_beat = 1'b1;
        end else if (!mem_req_q) begin
          advance = 1'b1;
        end else if (mem_ready_i) begin
          if (is_store_q) begin
            advance = 1'b1;
          end else begin
            state_d   = RWAIT;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end
      end
      RWAIT: begin
        if (mem_rvalid_i) begin
          for (int i = 0; i < LANES; i++)
            if (en_q[i]) buf_d[int'(e0_q) + i] = mem_rdata_i[i*ELEN +: ELEN];
          advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      e0_d = adv_e0;
      bb_d = adv_bb;
      if (adv_e0 >= EW'(vl_q)) begin
        state_d   = DONE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        en_d      = '0;
      end else begin
        state_d   = REQ;
        load_beat = 1'b1;
      end
    end
    // A fully masked beat loads with mem_req low and is skipped on the following cycle.
    if (load_beat) begin
      mem_req_d = |beat_en;
      mem_we_d  = is_store_q & (|beat_en);
      en_d      = beat_en;
      addr_d    = beat_addr;
      wdata_d   = beat_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      setup_q    <= 1'b0;
      is_store_q <= 1'b0;
      vl_q       <= '0;
      mask_q     <= '0;
      stride_q   <= '0;
      bb_q       <= '0;
      e0_q       <= '0;
      for (int j = 0; j < NELEM; j++) buf_q[j] <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      en_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      setup_q    <= setup_d;
      is_store_q <= is_store_d;
      vl_q       <= vl_d;
      mask_q     <= mask_d;
      stride_q   <= stride_d;
      bb_q       <= bb_d;
      e0_q       <= e0_d;
      for (int j = 0; j < NELEM; j++) buf_q[j] <= buf_d[j];
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_lane_en_o = en_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;

  always_comb begin
    vd_data_o = '0;
    vd_we_o   = '0;
    if (state_q == DONE) begin
      for (int j = 0; j < NELEM; j++) begin
        vd_data_o[j*ELEN +: ELEN] = buf_q[j];
        vd_we_o[j] = ~is_store_q & (j < int'(vl_q)) & mask_q[j];
      end
    end
  end
endmodule

// File: tb/tb_vector_strided_lsu.sv
// tb/tb_vector_strided_lsu.sv - randomized self-checking bench for vector_strided_lsu
// Expected beats, data and latency come from per-element address arithmetic, not beat sequencing.
module tb_vector_strided_lsu;
  localparam int VLEN = 256;
  localparam int ELEN = 32;
  localparam int LN   = 4;
  localparam int AW   = 32;
  localparam int NE   = VLEN / ELEN;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i, is_store_i;
  logic [AW-1:0]  base_i, stride_i;
  logic [3:0]     vl_i;
  logic [NE-1:0]  mask_i;
  logic [VLEN-1:0] vs3_i;
  logic           busy_o, done_o;
  logic [VLEN-1:0] vd_data_o;
  logic [NE-1:0]  vd_we_o;
  logic           mem_req_o, mem_we_o;
  logic [LN-1:0]  mem_lane_en_o;
  logic [LN*AW-1:0] mem_addr_o;
  logic [LN*ELEN-1:0] mem_wdata_o;
  logic           mem_ready_i, mem_rvalid_i;
  logic [LN*ELEN-1:0] mem_rdata_i;

  int total  = 0;
  int passed = 0;

  vector_strided_lsu #(.VLEN(VLEN), .ELEN(ELEN), .LANES(LN), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .is_store_i(is_store_i),
    .base_i(base_i), .stride_i(stride_i), .vl_i(vl_i), .mask_i(mask_i), .vs3_i(vs3_i),
    .busy_o(busy_o), .done_o(done_o), .vd_data_o(vd_data_o), .vd_we_o(vd_we_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_lane_en_o(mem_lane_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [LN-1:0] ref_en(input int k, input int v, input logic [NE-1:0] m);
    logic [LN-1:0] r;
    r = '0;
    for (int i = 0; i < LN; i++) r[i] = ((k*LN + i) < v) && m[k*LN + i];
    return r;
  endfunction

  // rmode: 0 ready always 1, 1 random ready, 2 ready low for 5 cycles on the first request
  task automatic run_op(input string nm, input logic st, input logic [31:0] b, input logic [31:0] s,
                        input int v, input logic [NE-1:0] m, input logic [VLEN-1:0] v3,
                        input int rmode, input bit rdly, input bit noise);
    logic [31:0]     ea [NE];
    logic [VLEN-1:0] evd;
    logic [NE-1:0]   ewe;
    logic [LN-1:0]   en;
    logic [LN*ELEN-1:0] pend_rd;
    int bq[$];
    int nb, qi, cyc, extra, cnt, held, k, dly, e;
    bit fin, r;
    nb = (v + LN - 1) / LN;
    for (int j = 0; j < NE; j++) begin
      ea[j]  = b + 32'(j) * s;
      ewe[j] = !st && (j < v) && m[j];
      evd[j*ELEN +: ELEN] = ewe[j] ? memval(ea[j]) : v3[j*ELEN +: ELEN];
    end
    for (int kk = 0; kk < nb; kk++) if (ref_en(kk, v, m) != '0) bq.push_back(kk);
    start_i = 1'b1; is_store_i = st; base_i = b; stride_i = s; vl_i = 4'(v); mask_i = m; vs3_i = v3;
    qi = 0; extra = 0; cnt = 0; held = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (noise) begin
        start_i = 1'($urandom_range(0, 1)); is_store_i = 1'($urandom_range(0, 1));
        base_i = $urandom(); stride_i = $urandom(); vl_i = 4'($urandom_range(0, 8));
        mask_i = NE'($urandom());
        for (int j = 0; j < NE; j++) vs3_i[j*ELEN +: ELEN] = $urandom();
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = pend_rd; end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        mem_rvalid_i = 1'b1;
        for (int i = 0; i < LN; i++) mem_rdata_i[i*ELEN +: ELEN] = $urandom();
      end
      if (done_o) begin
        fin = 1'b1; start_i = 1'b0; mem_rvalid_i = 1'b0;
        total++; if (cyc !== 2 + nb + extra) $display("FAIL %s done_cycle got=%0d exp=%0d", nm, cyc, 2 + nb + extra); else passed++;
        total++; if (vd_data_o !== evd) $display("FAIL %s vd_data got=%h exp=%h", nm, vd_data_o, evd); else passed++;
        total++; if (vd_we_o !== ewe) $display("FAIL %s vd_we got=%b exp=%b", nm, vd_we_o, ewe); else passed++;
        total++; if (busy_o !== 1'b1) $display("FAIL %s busy_at_done got=%b exp=1", nm, busy_o); else passed++;
        total++; if (qi !== bq.size()) $display("FAIL %s req_count got=%0d exp=%0d", nm, qi, bq.size()); else passed++;
      end else if (mem_req_o) begin
        total++;
        if (qi >= bq.size()) begin
          $display("FAIL %s unexpected_req got=%0d exp<%0d", nm, qi + 1, bq.size());
          mem_ready_i = 1'b1;
        end else begin
          passed++;
          k  = bq[qi];
          en = ref_en(k, v, m);
          total++; if (mem_lane_en_o !== en) $display("FAIL %s lane_en beat%0d got=%b exp=%b", nm, k, mem_lane_en_o, en); else passed++;
          total++; if (mem_we_o !== st) $display("FAIL %s mem_we beat%0d got=%b exp=%b", nm, k, mem_we_o, st); else passed++;
          for (int i = 0; i < LN; i++) begin
            e = k*LN + i;
            total++;
            if (mem_addr_o[i*AW +: AW] !== ea[e]) $display("FAIL %s addr e%0d got=%h exp=%h", nm, e, mem_addr_o[i*AW +: AW], ea[e]); else passed++;
            if (st) begin
              total++;
              if (mem_wdata_o[i*ELEN +: ELEN] !== v3[e*ELEN +: ELEN]) $display("FAIL %s wdata e%0d got=%h exp=%h", nm, e, mem_wdata_o[i*ELEN +: ELEN], v3[e*ELEN +: ELEN]); else passed++;
            end
          end
          case (rmode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 3) != 0);
            default: r = !(qi == 0 && held < 5);
          endcase
          mem_ready_i = r;
          if (!r) begin
            held++; extra++;
          end else begin
            qi++;
            if (!st) begin
              dly = rdly ? $urandom_range(1, 3) : 1;
              cnt = dly; extra += dly;
              for (int i = 0; i < LN; i++)
                pend_rd[i*ELEN +: ELEN] = en[i] ? memval(ea[k*LN + i]) : $urandom();
            end
          end
        end
      end else begin
        mem_ready_i = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!fin) begin
      total++; $display("FAIL %s timeout got=no_done exp=done", nm);
      start_i = 1'b0; mem_rvalid_i = 1'b0;
    end else begin
      @(negedge clk_i);
      total++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL %s after_done busy=%b done=%b exp=0,0", nm, busy_o, done_o); else passed++;
    end
    mem_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; is_store_i = 1'b0; base_i = '0; stride_i = '0; vl_i = '0;
    mask_i = '0; vs3_i = '0; mem_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL reset busy/done got=%b%b exp=00", busy_o, done_o); else passed++;
    total++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) $display("FAIL reset req/we got=%b%b exp=00", mem_req_o, mem_we_o); else passed++;
    total++; if (mem_lane_en_o !== '0 || vd_we_o !== '0) $display("FAIL reset en/vd_we got=%b/%b exp=0", mem_lane_en_o, vd_we_o); else passed++;
    total++; if (vd_data_o !== '0) $display("FAIL reset vd_data got=%h exp=0", vd_data_o); else passed++;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_unit_store;
    logic [VLEN-1:0] d;
    for (int j = 0; j < NE; j++) d[j*ELEN +: ELEN] = 32'hC0DE_0000 + 32'(j);
    run_op("unit_store", 1'b1, 32'h100, 32'd4, 8, 8'hFF, d, 0, 1'b0, 1'b0);
  endtask

  task automatic test_strided_load;
    run_op("strided_load", 1'b0, 32'h200, 32'hFFFF_FFF8, 6, 8'b0010_1101, {NE{32'hAAAA_AAAA}}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [VLEN-1:0] d;
    for (int j = 0; j < NE; j++) d[j*ELEN +: ELEN] = $urandom();
    run_op("backpressure", 1'b1, 32'h400, 32'd4, 8, 8'hFF, d, 2, 1'b0, 1'b0);
  endtask

  task automatic test_empty;
    run_op("vl_zero", 1'b1, 32'h500, 32'd4, 0, 8'hFF, {NE{32'h1111_2222}}, 0, 1'b0, 1'b0);
    run_op("masked_beat_store", 1'b1, 32'h600, 32'd4, 8, 8'h0F, {NE{32'h3333_4444}}, 0, 1'b0, 1'b0);
    run_op("masked_beat_load", 1'b0, 32'h700, 32'd4, 8, 8'h0F, {NE{32'h5555_6666}}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    run_op("addr_wrap", 1'b0, 32'hFFFF_FFF8, 32'd4, 4, 8'hFF, {NE{32'h7777_8888}}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_rwait;
    int w;
    start_i = 1'b1; is_store_i = 1'b0; base_i = 32'h300; stride_i = 32'd4; vl_i = 4'd4;
    mask_i = 8'hFF; vs3_i = '0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    w = 0;
    while (!mem_req_o && w < 10) begin @(negedge clk_i); w++; end
    total++; if (!mem_req_o) $display("FAIL rst_rwait no_req got=0 exp=1"); else passed++;
    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    total++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rst_rwait after_reset req=%b busy=%b exp=0,0", mem_req_o, busy_o); else passed++;
    mem_rvalid_i = 1'b1; mem_rdata_i = {4{32'hDEAD_BEEF}};
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++; if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rst_rwait late_rvalid done=%b busy=%b exp=0,0", done_o, busy_o); else passed++;
      @(negedge clk_i);
    end
    mem_ready_i = 1'b1;
    run_op("load_after_reset", 1'b0, 32'h300, 32'd4, 8, 8'hFF, {NE{32'h0BAD_F00D}}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [VLEN-1:0] d;
    logic [31:0] s;
    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < NE; j++) d[j*ELEN +: ELEN] = $urandom();
      s = 32'($urandom_range(0, 64)) - 32'd32;
      run_op("random", 1'($urandom_range(0, 1)), $urandom(), s, $urandom_range(0, 8),
             NE'($urandom()), d, 1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    run_op("b2b_store", 1'b1, 32'h800, 32'd8, 7, 8'h7F, {NE{32'h0102_0304}}, 0, 1'b0, 1'b0);
    run_op("b2b_load", 1'b0, 32'h900, 32'hFFFF_FFFC, 5, 8'h1B, {NE{32'h0506_0708}}, 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unit_store();
    test_strided_load();
    test_backpressure();
    test_empty();
    test_wrap();
    test_reset_rwait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
